uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side buffer downstream of the UART receiver. Drains received words from the
//  receiver's ready/read-enable handshake into a synchronous FIFO. Presents them to the
//  chip-side consumer as first-word-fall-through with level/threshold status.
//  Decouples line rate from consumer service latency.
// PARAMETERS
//  WIDTH_DATA  8  word width; matches receiver data width
//  DEPTH_LOG2  4  FIFO depth = 2**DEPTH_LOG2 entries (16)
//  THRESHOLD   8  o_thr asserts when count >= THRESHOLD (1..2**DEPTH_LOG2)
// PORTS
//  i_clk      in   1              system clock, rising edge
//  i_nrst     in   1              synchronous reset, active low
//  i_rx_rdy   in   1              receiver holds a word
//  i_rx_data  in   WIDTH_DATA     receiver word, valid while i_rx_rdy=1
//  o_rx_re    out  1              one-cycle pulse: take word from receiver
//  o_data     out  WIDTH_DATA     head of FIFO (FWFT), valid when o_empty=0
//  i_rd       in   1              consumer pop; ignored when o_empty=1
//  o_empty    out  1              FIFO holds 0 words
//  o_full     out  1              FIFO holds 2**DEPTH_LOG2 words
//  o_count    out  DEPTH_LOG2+1   current occupancy
//  o_thr      out  1              count >= THRESHOLD
//  o_stall    out  1              sticky: receiver word waited because FIFO full
//  i_clr      in   1              sync flush: count->0, o_stall->0
// BEHAVIOUR
//  - All state updates on rising i_clk. i_nrst=0 at an edge overrides everything,
//    including mid-transfer. Reset values:
//      o_rx_re=0, o_empty=1, o_full=0, o_count=0, o_thr=0, o_stall=0, o_data=0,
//      FSM=IDLE.
//    RAM contents are not reset.
//  - Drain FSM, states IDLE, TAKE, HOLD:
//      IDLE: if i_rx_rdy & ~full_next -> TAKE.
//      TAKE: o_rx_re=1 for exactly this cycle; i_rx_data written at the edge
//            ending TAKE -> HOLD.
//      HOLD: one guard cycle, so the receiver's registered rdy can fall; -> IDLE.
//    Maximum intake is 1 word per 3 cycles, far above any line rate.
//  - full_next = count after this cycle's pop == DEPTH. A same-cycle consumer pop
//    therefore unblocks a full FIFO for the next IDLE decision.
//  - o_stall sets when FSM=IDLE & i_rx_rdy=1 & o_full=1. It is cleared only by reset
//    or i_clr. No word is ever dropped by this block.
//  - Pointers are DEPTH_LOG2 bits and wrap modulo depth. Count is DEPTH_LOG2+1 bits.
//    Write and pop in the same cycle: count unchanged, both pointers advance.
//  - i_rd with o_empty=1: no effect. A write into an empty FIFO shows on o_data and
//    o_empty=0 one cycle after the TAKE edge.
//    Simultaneous write and pop with count=1: head advances to the new word and
//    o_empty stays 0.
//  - o_full, o_empty and o_thr are registered, derived from next count. They change
//    on the same edge as o_count.
//  - i_clr: pointers and count -> 0, o_stall -> 0, FSM -> IDLE. Takes priority over
//    a same-cycle write or pop. A TAKE in progress completes its o_rx_re pulse, but
//    that word is discarded.
// STRUCTURE
//  - Shared package uart_pkg: drain FSM state encoding (IDLE=2'd0, TAKE=2'd1,
//    HOLD=2'd2) and a width function for count (DEPTH_LOG2+1).
//  - Sub-module sync_fifo: storage, pointers, count and flags, with generic
//    write/pop ports. It is reused later for the transmit-side buffer.
//  - The top level holds only the drain FSM, o_stall and the i_clr fan-out.
// TESTING
//  1. Reset mid-TAKE (i_nrst=0 one cycle): next cycle o_rx_re=0, o_count=0,
//     o_empty=1, o_stall=0.
//  2. Single word 8'hA5 (i_rx_rdy=1 until o_rx_re): exactly one o_rx_re pulse;
//     o_data=8'hA5 and o_count=1 on the cycle after TAKE.
//     Then i_rd=1 -> o_empty=1 next cycle.
//  3. Fill 16 words 8'h00..8'h0F, no pops: o_thr rises at count 8, o_full at 16.
//     17th i_rx_rdy: o_rx_re stays 0 and o_stall=1.
//     One pop -> word 8'h10 accepted; words then drain in order 01..10.
//  4. Wrap-around: 40 words streamed with the consumer popping each as it appears.
//     Output order is 0..39 with no loss or duplication; o_count never exceeds 2.
//  5. Count=1 with pop and TAKE-write on the same edge: o_count stays 1, o_empty
//     stays 0, o_data becomes the new word.
//  6. i_clr with count=5 and o_stall=1: next cycle o_count=0, o_empty=1, o_stall=0.
//     A word in TAKE that cycle is not stored.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive-side buffer and the generic
// synchronous FIFO it is built on.
//   drain_state_t : encoding of the receiver drain state machine
//   count_width() : number of bits needed for a FIFO occupancy count
// -----------------------------------------------------------------------------
package uart_pkg;

   // Drain FSM: IDLE waits for a word, TAKE strobes the receiver,
   // HOLD gives the receiver one cycle to drop its registered ready.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TAKE = 2'd1,
      ST_HOLD = 2'd2
   } drain_state_t;

   // Occupancy runs 0..2**depth_log2 inclusive, so it needs one extra bit.
   function automatic int count_width(input int depth_log2);
      return depth_log2 + 32'sd1;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Generic single-clock first-word-fall-through FIFO with registered status.
// The head word is held in a register so o_rdata is glitch-free and valid
// whenever o_empty is low.
// Ports:
//   i_clk        system clock, rising edge
//   i_nrst       synchronous reset, active low
//   i_clr        synchronous flush (pointers/count to zero), beats wr/rd
//   i_wr         write strobe; accepted when not full or popping this cycle
//   i_wdata      write word
//   i_rd         pop strobe; ignored when empty
//   o_rdata      head of FIFO (registered)
//   o_empty      occupancy == 0 (registered)
//   o_full       occupancy == depth (registered)
//   o_thr        occupancy >= THRESHOLD (registered)
//   o_count      occupancy (registered)
//   o_full_next  combinational: occupancy after this cycle's pop == depth
// -----------------------------------------------------------------------------
module sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH_DATA = 8,
   parameter int DEPTH_LOG2 = 4,
   parameter int THRESHOLD  = 8
)(
   input  logic                                  i_clk,
   input  logic                                  i_nrst,
   input  logic                                  i_clr,
   input  logic                                  i_wr,
   input  logic [WIDTH_DATA-1:0]                 i_wdata,
   input  logic                                  i_rd,
   output logic [WIDTH_DATA-1:0]                 o_rdata,
   output logic                                  o_empty,
   output logic                                  o_full,
   output logic                                  o_thr,
   output logic [count_width(DEPTH_LOG2)-1:0]    o_count,
   output logic                                  o_full_next
);

   localparam int                      CW       = count_width(DEPTH_LOG2);
   localparam int                      DEPTH    = 2 ** DEPTH_LOG2;
   localparam logic [CW-1:0]           DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0]           THR_C    = CW'(THRESHOLD);
   localparam logic [CW-1:0]           CNT_ZERO = CW'(0);
   localparam logic [CW-1:0]           CNT_ONE  = CW'(1);
   localparam logic [DEPTH_LOG2-1:0]   PTR_ONE  = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2-1:0]   PTR_ZERO = DEPTH_LOG2'(0);

   logic [WIDTH_DATA-1:0]   r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   r_wr_ptr;
   logic [DEPTH_LOG2-1:0]   r_rd_ptr;
   logic [CW-1:0]           r_count;
   logic                    r_empty;
   logic                    r_full;
   logic                    r_thr;
   logic [WIDTH_DATA-1:0]   r_data;

   logic                    w_pop;
   logic                    w_wr_en;
   logic [DEPTH_LOG2-1:0]   w_rd_ptr_inc;
   logic [CW-1:0]           w_count_after_pop;
   logic [CW-1:0]           w_count_nxt;
   logic [WIDTH_DATA-1:0]   w_data_nxt;

   // Handshake qualification, next occupancy and next head word.
   always_comb begin
      w_pop             = i_rd & ~r_empty;
      // A pop frees a slot on the same edge, so a full FIFO may still accept.
      w_wr_en           = i_wr & (~r_full | w_pop);
      w_rd_ptr_inc      = r_rd_ptr + PTR_ONE;
      w_count_after_pop = r_count;
      w_count_nxt       = r_count;
      w_data_nxt        = r_data;

      if (w_pop) begin
         w_count_after_pop = r_count - CNT_ONE;
      end else begin
         w_count_after_pop = r_count;
      end

      if (w_wr_en) begin
         w_count_nxt = w_count_after_pop + CNT_ONE;
      end else begin
         w_count_nxt = w_count_after_pop;
      end

      // Head register: after a pop the next word is already in RAM unless the
      // FIFO drains to zero, in which case only a same-cycle write can refill it.
      if (w_pop) begin
         if (w_count_after_pop == CNT_ZERO) begin
            if (w_wr_en) begin
               w_data_nxt = i_wdata;
            end else begin
               w_data_nxt = r_data;
            end
         end else begin
            w_data_nxt = r_mem[w_rd_ptr_inc];
         end
      end else if (w_wr_en & r_empty) begin
         w_data_nxt = i_wdata;
      end else begin
         w_data_nxt = r_data;
      end
   end

   assign o_full_next = (w_count_after_pop == DEPTH_C);

   // Storage array; deliberately not reset.
   always_ff @(posedge i_clk) begin
      if (i_nrst & ~i_clr & w_wr_en) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers, occupancy, status flags and head register.
   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         r_wr_ptr <= PTR_ZERO;
         r_rd_ptr <= PTR_ZERO;
         r_count  <= CNT_ZERO;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
         r_thr    <= 1'b0;
         r_data   <= {WIDTH_DATA{1'b0}};
      end else if (i_clr) begin
         r_wr_ptr <= PTR_ZERO;
         r_rd_ptr <= PTR_ZERO;
         r_count  <= CNT_ZERO;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
         r_thr    <= 1'b0;
         r_data   <= {WIDTH_DATA{1'b0}};
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_ptr_inc;
         end
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == CNT_ZERO);
         r_full  <= (w_count_nxt == DEPTH_C);
         r_thr   <= (w_count_nxt >= THR_C);
         r_data  <= w_data_nxt;
      end
   end

   assign o_rdata = r_data;
   assign o_empty = r_empty;
   assign o_full  = r_full;
   assign o_thr   = r_thr;
   assign o_count = r_count;

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side buffer behind the UART receiver. A three-state drain FSM pulls
// words out of the receiver's ready/read-enable handshake into a FWFT FIFO,
// which the chip-side consumer pops at its own pace.
// Ports:
//   i_clk      system clock, rising edge
//   i_nrst     synchronous reset, active low
//   i_rx_rdy   receiver holds a word
//   i_rx_data  receiver word, valid while i_rx_rdy=1
//   o_rx_re    one-cycle pulse: take word from receiver
//   o_data     head of FIFO, valid when o_empty=0
//   i_rd       consumer pop; ignored when empty
//   o_empty    FIFO holds 0 words
//   o_full     FIFO holds 2**DEPTH_LOG2 words
//   o_count    current occupancy
//   o_thr      occupancy >= THRESHOLD
//   o_stall    sticky: a receiver word had to wait because the FIFO was full
//   i_clr      synchronous flush of FIFO, FSM and o_stall
// -----------------------------------------------------------------------------
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH_DATA = 8,
   parameter int DEPTH_LOG2 = 4,
   parameter int THRESHOLD  = 8
)(
   input  logic                                  i_clk,
   input  logic                                  i_nrst,
   input  logic                                  i_rx_rdy,
   input  logic [WIDTH_DATA-1:0]                 i_rx_data,
   output logic                                  o_rx_re,
   output logic [WIDTH_DATA-1:0]                 o_data,
   input  logic                                  i_rd,
   output logic                                  o_empty,
   output logic                                  o_full,
   output logic [count_width(DEPTH_LOG2)-1:0]    o_count,
   output logic                                  o_thr,
   output logic                                  o_stall,
   input  logic                                  i_clr
);

   drain_state_t   r_state;
   drain_state_t   w_state_nxt;
   logic           r_rx_re;
   logic           r_stall;
   logic           w_take;
   logic           w_stall_set;
   logic           w_full_next;
   logic           w_fifo_full;

   // Drain FSM next state and stall detection.
   always_comb begin
      w_state_nxt = r_state;
      w_stall_set = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // full_next already credits a same-cycle pop, so a consumer read
            // unblocks a full FIFO without losing a cycle.
            if (i_rx_rdy & ~w_full_next) begin
               w_state_nxt = ST_TAKE;
            end else begin
               w_state_nxt = ST_IDLE;
            end
            w_stall_set = i_rx_rdy & w_fifo_full;
         end
         ST_TAKE: begin
            w_state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register; o_rx_re is registered as "next state is TAKE".
   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         r_state <= ST_IDLE;
         r_rx_re <= 1'b0;
      end else if (i_clr) begin
         r_state <= ST_IDLE;
         r_rx_re <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_rx_re <= (w_state_nxt == ST_TAKE);
      end
   end

   // Sticky stall flag, cleared only by reset or flush.
   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         r_stall <= 1'b0;
      end else if (i_clr) begin
         r_stall <= 1'b0;
      end else if (w_stall_set) begin
         r_stall <= 1'b1;
      end
   end

   // The word is written on the edge that ends TAKE; a flush on that edge wins
   // inside the FIFO, which discards it.
   assign w_take = (r_state == ST_TAKE);

   sync_fifo #(
      .WIDTH_DATA (WIDTH_DATA),
      .DEPTH_LOG2 (DEPTH_LOG2),
      .THRESHOLD  (THRESHOLD)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_nrst      (i_nrst),
      .i_clr       (i_clr),
      .i_wr        (w_take),
      .i_wdata     (i_rx_data),
      .i_rd        (i_rd),
      .o_rdata     (o_data),
      .o_empty     (o_empty),
      .o_full      (w_fifo_full),
      .o_thr       (o_thr),
      .o_count     (o_count),
      .o_full_next (w_full_next)
   );

   assign o_full  = w_fifo_full;
   assign o_rx_re = r_rx_re;
   assign o_stall = r_stall;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo. Inputs change 1 ns after the rising edge,
// outputs are sampled at the same point (registered values of that edge).
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

   logic       clk;
   logic       i_nrst;
   logic       i_rx_rdy;
   logic [7:0] i_rx_data;
   logic       o_rx_re;
   logic [7:0] o_data;
   logic       i_rd;
   logic       o_empty;
   logic       o_full;
   logic [4:0] o_count;
   logic       o_thr;
   logic       o_stall;
   logic       i_clr;

   int n_checks;
   int n_errors;

   uart_rx_fifo #(
      .WIDTH_DATA (8),
      .DEPTH_LOG2 (4),
      .THRESHOLD  (8)
   ) dut (
      .i_clk     (clk),
      .i_nrst    (i_nrst),
      .i_rx_rdy  (i_rx_rdy),
      .i_rx_data (i_rx_data),
      .o_rx_re   (o_rx_re),
      .o_data    (o_data),
      .i_rd      (i_rd),
      .o_empty   (o_empty),
      .o_full    (o_full),
      .o_count   (o_count),
      .o_thr     (o_thr),
      .o_stall   (o_stall),
      .i_clr     (i_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) until the DUT is in its TAKE cycle.
   task automatic wait_re(input string tag, output bit seen);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         seen = o_rx_re;
      end
      chk_eq(tag, 32'(seen), 32'd1);
   endtask

   // Present one word, hold it until the TAKE edge has written it.
   task automatic send_word(input logic [7:0] d);
      bit seen;
      i_rx_rdy  = 1'b1;
      i_rx_data = d;
      wait_re("send_re", seen);
      i_rx_rdy = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bit  seen;
      int  pulses;
      int  next_send;
      int  next_exp;
      int  max_cnt;
      int  cyc;
      bit  in_take;

      n_checks  = 0;
      n_errors  = 0;
      i_nrst    = 1'b0;
      i_rx_rdy  = 1'b0;
      i_rx_data = 8'h00;
      i_rd      = 1'b0;
      i_clr     = 1'b0;
      tick();
      tick();
      i_nrst = 1'b1;

      // Reset state
      chk_eq("rst_rx_re", 32'(o_rx_re), 32'd0);
      chk_eq("rst_empty", 32'(o_empty), 32'd1);
      chk_eq("rst_full",  32'(o_full),  32'd0);
      chk_eq("rst_count", 32'(o_count), 32'd0);
      chk_eq("rst_thr",   32'(o_thr),   32'd0);
      chk_eq("rst_stall", 32'(o_stall), 32'd0);
      chk_eq("rst_data",  32'(o_data),  32'd0);

      // 1. Reset while in TAKE
      i_rx_rdy  = 1'b1;
      i_rx_data = 8'h33;
      wait_re("t1_re", seen);
      i_nrst   = 1'b0;
      i_rx_rdy = 1'b0;
      tick();
      i_nrst = 1'b1;
      chk_eq("t1_rx_re", 32'(o_rx_re), 32'd0);
      chk_eq("t1_count", 32'(o_count), 32'd0);
      chk_eq("t1_empty", 32'(o_empty), 32'd1);
      chk_eq("t1_stall", 32'(o_stall), 32'd0);
      tick();
      chk_eq("t1_count_later", 32'(o_count), 32'd0);

      // 2. Single word A5
      i_rx_rdy  = 1'b1;
      i_rx_data = 8'hA5;
      wait_re("t2_re", seen);
      pulses   = int'(seen);
      i_rx_rdy = 1'b0;
      tick();
      chk_eq("t2_data",  32'(o_data),  32'hA5);
      chk_eq("t2_count", 32'(o_count), 32'd1);
      chk_eq("t2_empty", 32'(o_empty), 32'd0);
      for (int k = 0; k < 6; k++) begin
         pulses += int'(o_rx_re);
         tick();
      end
      chk_eq("t2_pulses", 32'(pulses), 32'd1);
      i_rd = 1'b1;
      tick();
      i_rd = 1'b0;
      chk_eq("t2_pop_empty", 32'(o_empty), 32'd1);
      chk_eq("t2_pop_count", 32'(o_count), 32'd0);
      // Pop on empty has no effect
      i_rd = 1'b1;
      tick();
      i_rd = 1'b0;
      chk_eq("t2_rd_empty_cnt", 32'(o_count), 32'd0);
      chk_eq("t2_rd_empty_emp", 32'(o_empty), 32'd1);

      // 3. Fill to full, stall, unblock by pop, drain in order
      for (int i = 0; i < 16; i++) begin
         send_word(8'(i));
         chk_eq("t3_count", 32'(o_count), 32'(i + 1));
         chk_eq("t3_thr",   32'(o_thr),   32'((i + 1) >= 8));
         chk_eq("t3_full",  32'(o_full),  32'((i + 1) == 16));
      end
      chk_eq("t3_head", 32'(o_data), 32'h00);
      i_rx_rdy  = 1'b1;
      i_rx_data = 8'h10;
      pulses    = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         pulses += int'(o_rx_re);
      end
      chk_eq("t3_no_take_full", 32'(pulses),  32'd0);
      chk_eq("t3_stall",        32'(o_stall), 32'd1);
      chk_eq("t3_count_full",   32'(o_count), 32'd16);
      i_rd = 1'b1;
      tick();
      i_rd = 1'b0;
      chk_eq("t3_take_after_pop", 32'(o_rx_re), 32'd1);
      chk_eq("t3_count_pop",      32'(o_count), 32'd15);
      i_rx_rdy = 1'b0;
      tick();
      chk_eq("t3_count_refill", 32'(o_count), 32'd16);
      for (int i = 1; i <= 16; i++) begin
         chk_eq("t3_drain", 32'(o_data), 32'(i));
         i_rd = 1'b1;
         tick();
         i_rd = 1'b0;
      end
      chk_eq("t3_drained_empty", 32'(o_empty), 32'd1);
      chk_eq("t3_stall_sticky",  32'(o_stall), 32'd1);

      // 4. Streaming 40 words through wrapping pointers
      next_send = 0;
      next_exp  = 0;
      max_cnt   = 0;
      cyc       = 0;
      in_take   = 1'b0;
      while (next_exp < 40 && cyc < 600) begin
         if (!o_empty) begin
            chk_eq("t4_order", 32'(o_data), 32'(next_exp));
            next_exp++;
            i_rd = 1'b1;
         end else begin
            i_rd = 1'b0;
         end
         i_rx_data = 8'(next_send);
         i_rx_rdy  = (next_send < 40) && !in_take;
         tick();
         cyc++;
         if (in_take) next_send++;
         in_take = o_rx_re;
         if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
      end
      i_rd     = 1'b0;
      i_rx_rdy = 1'b0;
      chk_eq("t4_received", 32'(next_exp), 32'd40);
      chk_eq("t4_cnt_le2",  32'(max_cnt <= 2), 32'd1);
      tick();
      tick();
      chk_eq("t4_no_dup", 32'(o_empty), 32'd1);

      // 5. Count=1, pop and TAKE-write on the same edge
      send_word(8'h55);
      tick();
      chk_eq("t5_pre_data",  32'(o_data),  32'h55);
      chk_eq("t5_pre_count", 32'(o_count), 32'd1);
      i_rx_rdy  = 1'b1;
      i_rx_data = 8'h66;
      wait_re("t5_re", seen);
      i_rd     = 1'b1;
      i_rx_rdy = 1'b0;
      tick();
      i_rd = 1'b0;
      chk_eq("t5_count", 32'(o_count), 32'd1);
      chk_eq("t5_empty", 32'(o_empty), 32'd0);
      chk_eq("t5_data",  32'(o_data),  32'h66);
      i_rd = 1'b1;
      tick();
      i_rd = 1'b0;
      chk_eq("t5_final_empty", 32'(o_empty), 32'd1);

      // 6. Flush with count=5 and stall set, word in TAKE discarded
      for (int i = 0; i < 5; i++) begin
         send_word(8'(8'h20 + i));
      end
      chk_eq("t6_pre_count", 32'(o_count), 32'd5);
      chk_eq("t6_pre_stall", 32'(o_stall), 32'd1);
      i_rx_rdy  = 1'b1;
      i_rx_data = 8'h77;
      wait_re("t6_re", seen);
      i_clr = 1'b1;
      tick();
      i_clr    = 1'b0;
      i_rx_rdy = 1'b0;
      chk_eq("t6_count", 32'(o_count), 32'd0);
      chk_eq("t6_empty", 32'(o_empty), 32'd1);
      chk_eq("t6_stall", 32'(o_stall), 32'd0);
      chk_eq("t6_thr",   32'(o_thr),   32'd0);
      for (int k = 0; k < 4; k++) tick();
      chk_eq("t6_discard_count", 32'(o_count), 32'd0);
      chk_eq("t6_discard_empty", 32'(o_empty), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
